// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: read-address and tile sequencer for an N x N systolic
// matrix-multiply core. Walks C = A * B tile by tile, streaming K operand
// beats per tile, then waiting DRAIN_LAT cycles for the array to drain
// before reporting the finished C tile index.
module mm_tile_sequencer #(
    parameter int N         = 4,
    parameter int M         = 8,
    parameter int K         = 8,
    parameter int P         = 8,
    parameter int DRAIN_LAT = 2 * N - 1,
    localparam int TR       = M / N,
    localparam int TC       = P / N,
    localparam int T        = TR * TC,
    localparam int AW_A     = (TR * K > 1) ? $clog2(TR * K) : 1,
    localparam int AW_B     = (TC * K > 1) ? $clog2(TC * K) : 1,
    localparam int AW_C     = (T > 1) ? $clog2(T) : 1,
    localparam int KW       = (K > 1) ? $clog2(K) : 1,
    localparam int RW       = (TR > 1) ? $clog2(TR) : 1,
    localparam int CW       = (TC > 1) ? $clog2(TC) : 1,
    localparam int DW       = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW_A-1:0] rd_addr_A,
    output logic [AW_B-1:0] rd_addr_B,
    output logic [KW-1:0]   k_cntr,
    output logic [RW-1:0]   row_tile,
    output logic [CW-1:0]   col_tile,
    output logic            acc_first,
    output logic            acc_last,
    output logic            tile_done,
    output logic [AW_C-1:0] c_addr
);

    // Reject operand shapes that cannot be tiled onto the array.
    if (M % N != 0) begin : g_bad_m
        $error("mm_tile_sequencer: M (%0d) must be a multiple of N (%0d)", M, N);
    end
    if (P % N != 0) begin : g_bad_p
        $error("mm_tile_sequencer: P (%0d) must be a multiple of N (%0d)", P, N);
    end
    if (K < 1) begin : g_bad_k
        $error("mm_tile_sequencer: K (%0d) must be at least 1", K);
    end
    if (DRAIN_LAT < 1) begin : g_bad_drain
        $error("mm_tile_sequencer: DRAIN_LAT (%0d) must be at least 1", DRAIN_LAT);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic last_beat;
    logic last_row;
    logic last_col;
    logic drain_zero;

    assign last_beat  = (k_q == KW'(K - 1));
    assign last_row   = (row_q == RW'(TR - 1));
    assign last_col   = (col_q == CW'(TC - 1));
    assign drain_zero = (drain_q == '0);

    // Sequencer state and counters; synchronous reset abandons any tile in flight.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others, whatever the statement order.
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and pulse decode; every pulse is qualified by !stall.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        busy      = 1'b0;
        rd_en     = 1'b0;
        acc_first = 1'b0;
        acc_last  = 1'b0;
        tile_done = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Counters are already zero here; stall has no effect in IDLE.
                if (start) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    drain_d = '0;
                end
            end

            S_STREAM: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en     = 1'b1;
                    acc_first = (k_q == '0);
                    acc_last  = last_beat;
                    if (last_beat) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(DRAIN_LAT - 1);
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (!stall) begin
                    if (drain_zero) begin
                        tile_done = 1'b1;
                        k_d       = '0;
                        if (last_row && last_col) begin
                            // Final tile: return to IDLE with all counters cleared.
                            done    = 1'b1;
                            state_d = S_IDLE;
                            row_d   = '0;
                            col_d   = '0;
                        end else begin
                            // Column tile is the inner loop, row tile the outer.
                            state_d = S_STREAM;
                            if (last_col) begin
                                col_d = '0;
                                row_d = row_q + 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Addresses and tile index are pure functions of the registered counters.
    assign k_cntr    = k_q;
    assign row_tile  = row_q;
    assign col_tile  = col_q;
    assign rd_addr_A = AW_A'(int'(row_q) * K + int'(k_q));
    assign rd_addr_B = AW_B'(int'(col_q) * K + int'(k_q));
    assign c_addr    = AW_C'(int'(row_q) * TC + int'(col_q));

endmodule

// File: doc/mm_tile_sequencer.md
# mm_tile_sequencer

Parametrised read-address and tile sequencer for the N×N systolic matrix-multiply core. It computes C[M×P] = A[M×K] · B[K×P] over rectangular operands, tile by tile, with start/done handshake, stall back-pressure and accumulator framing. It sits between the A/B operand bank memories and the systolic array, and supplies C write-back tile indices to the output stage.

## Interface
Parameters:
- N, 4, systolic array dimension (rows = columns).
- M, 8, rows of A and C; must be a multiple of N.
- K, 8, inner dimension (columns of A, rows of B); ≥1.
- P, 8, columns of B and C; must be a multiple of N.
- DRAIN_LAT, 2*N-1, cycles from last operand beat until the tile result is complete; ≥1.
- Derived: TR=M/N, TC=P/N, T=TR*TC; AW_A=max(1,clog2(TR*K)), AW_B=max(1,clog2(TC*K)), AW_C=max(1,clog2(T)), KW=max(1,clog2(K)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to run a full multiply; honoured only in IDLE.
- stall  in  1  freeze all sequencing while high (not in IDLE).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on final tile completion.
- rd_en  out  1  operand beat valid this cycle.
- rd_addr_A  out  AW_A  A-bank address = row_tile*K + k.
- rd_addr_B  out  AW_B  B-bank address = col_tile*K + k.
- k_cntr  out  KW  inner-dimension beat index.
- row_tile  out  max(1,clog2(TR))  current A row tile.
- col_tile  out  max(1,clog2(TC))  current B column tile.
- acc_first  out  1  rd_en beat with k=0 (array clears accumulators).
- acc_last  out  1  rd_en beat with k=K-1.
- tile_done  out  1  one-cycle pulse: tile result ready.
- c_addr  out  AW_C  C tile index = row_tile*TC + col_tile, valid with tile_done.

## Operation
- FSM states IDLE, STREAM, DRAIN.
- IDLE: counters zero; start → STREAM at (row_tile,col_tile,k)=(0,0,0).
- STREAM: one beat per non-stalled cycle; k increments; at k=K-1 → DRAIN with drain counter = DRAIN_LAT-1.
- DRAIN: rd_en=0; counter decrements per non-stalled cycle; tile_done and c_addr asserted while counter==0 (and not stalled). Next: if last tile (row_tile=TR-1, col_tile=TC-1) → IDLE with done asserted in the same cycle as that tile_done; else → STREAM, k=0, next tile.
- Tile order: col_tile inner, row_tile outer; col_tile wraps TC-1→0 with row_tile increment.
- rd_en, acc_first, acc_last, tile_done and done = decoded state/counters AND !stall; addresses and counters come from registers.
- stall: holds state, k, tiles and drain counter; all pulse outputs are 0 while stall=1.
- start while busy ignored (including the done cycle). stall in IDLE ignored.
- K=1: acc_first and acc_last are asserted on the same beat.
- Illegal parameters (M%N, P%N ≠ 0, K<1, DRAIN_LAT<1): simulation $error at elaboration.

## Timing
- Reset: all outputs 0, state IDLE, all counters 0; takes effect at the next clk edge, including mid-run. Any in-flight tile is abandoned.
- Start sampled at edge e → first beat (busy=1, rd_en=1, k=0) in cycle e+1.
- Unstalled tile length K+DRAIN_LAT cycles. Run length T*(K+DRAIN_LAT) cycles; done is asserted in its last cycle, and busy drops the cycle after.
- Each stalled cycle delays every later event by exactly one cycle.
- Next tile's first beat is the cycle right after the previous tile_done; no bubble.

## Test plan
- Defaults, start pulse, no stall: tile (0,0) A 0..7 and B 0..7; then 7 cycles rd_en=0; tile_done with c_addr=0. Tile (0,1): A 0..7, B 8..15. Tile (1,0): A 8..15, B 0..7. Tile (1,1) ends with done, c_addr=3, 60 cycles after first beat inclusive; busy low next cycle.
- Stall for 3 cycles when k=4 of tile (0,0): rd_en=0, k holds 4, addresses hold 4/4. Resumes at k=4; done 3 cycles late. Stall in DRAIN extends drain 1:1.
- Start pulses mid-run and on the done cycle: ignored (exactly 4 tile_done pulses). Start one cycle after done: new run from tile (0,0).
- rst during tile (1,0) at k=3: next cycle busy=0, rd_en=0, all addresses and counters 0, no tile_done. A subsequent start restarts at (0,0).
- N=2, M=4, K=3, P=6, DRAIN_LAT=1: T=6, 4 cycles per tile, 24-cycle run. Tile (0,2) B addresses 6,7,8. c_addr sequence 0..5.
- K=1, N=2, M=2, P=2: single beat with acc_first=acc_last=1; tile_done and done DRAIN_LAT cycles later.
